// File: rtl/and_vector_sequencer_pkg.sv
// Shared types and constants for the AND-gate vector sequencer.
// Imported by the top level and its settle timer.
package and_vector_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;
  localparam int CNT_W       = 4;
  localparam int ERR_W       = 3;

  localparam logic [VEC_W-1:0] LAST_VEC =
    VEC_W'(NUM_VECTORS - 1);

  function automatic logic expected_y(
    input logic [VEC_W-1:0] v
  );
    return v == LAST_VEC;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times the settle interval of one vector.
// expire is high once the loaded interval has elapsed.
module settle_timer
  import and_vector_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/and_vector_sequencer.sv
// Drives the four 2-bit vectors into an external AND gate
// and scores its responses.
module and_vector_sequencer
  import and_vector_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec
);

  state_t           state;
  state_t           state_nxt;
  logic [VEC_W-1:0] vec;
  logic             accept;
  logic             load;
  logic             tmr_en;
  logic             expire;
  logic             last;
  logic             mismatch;

  assign last     = (vec == LAST_VEC);
  assign mismatch = (dut_y != expected_y(vec));

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .en    (tmr_en),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE,
      DONE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (expire) state_nxt = CHECK;
      CHECK:   state_nxt = last ? DONE : SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    accept = 1'b0;
    load   = 1'b0;
    tmr_en = 1'b0;
    unique case (state)
      IDLE: begin
        accept = start;
        load   = start;
      end
      SETTLE: begin
        busy   = 1'b1;
        tmr_en = 1'b1;
      end
      CHECK: begin
        busy = 1'b1;
        load = !last;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        load   = start;
      end
      default: ;
    endcase
  end

  // fail_vec only captures the first mismatch of a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
    end else if (accept) begin
      vec       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
    end else if (state == CHECK) begin
      if (mismatch) begin
        err_count <= err_count + ERR_W'(1);
        if (err_count == '0) fail_vec <= vec;
      end
      if (!last) vec <= vec + VEC_W'(1);
    end
  end

  assign dut_a = vec[1];
  assign dut_b = vec[0];
  assign pass  = done && (err_count == '0);

endmodule

// File: tb/tb_and_vector_sequencer.sv
// Directed bench for and_vector_sequencer with a modelled
// gate under test and a queue of expected run results.
module tb_and_vector_sequencer;

  localparam int S       = 4;
  localparam int RUN_LAT = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dut_a;
  logic       dut_b;
  logic       dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;

  // 0: AND, 1: tied 1, 2: tied 0, 3: OR
  int mode = 0;
  int checks = 0;
  int passes = 0;
  int fails = 0;

  typedef struct {
    int err;
    int fv;
    int pass;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always_comb begin
    dut_y = 1'b0;
    case (mode)
      0:       dut_y = dut_a & dut_b;
      1:       dut_y = 1'b1;
      2:       dut_y = 1'b0;
      default: dut_y = dut_a | dut_b;
    endcase
  end

  and_vector_sequencer #(
    .SETTLE_CYCLES(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dut_a    (dut_a),
    .dut_b    (dut_b),
    .dut_y    (dut_y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int m);
    exp_t e;
    e.err  = 0;
    e.fv   = 0;
    for (int v = 0; v < 4; v++) begin
      bit a;
      bit b;
      bit y;
      bit want;
      a    = (v >= 2);
      b    = (v % 2) == 1;
      want = (v == 3);
      case (m)
        0:       y = a && b;
        1:       y = 1'b1;
        2:       y = 1'b0;
        default: y = a || b;
      endcase
      if (y != want) begin
        if (e.err == 0) e.fv = v;
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ab"},   {dut_a, dut_b}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"},  err_count, 0);
    check({tag, "_fv"},   fail_vec, 0);
  endtask

  task automatic run_one(input string tag, input int m);
    exp_t e;
    int   lat;
    int   bad;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(model(m));
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bad = 0;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) bad++;
      if ({dut_a, dut_b} !== 2'(lat / (S + 1))) bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, RUN_LAT);
    check({tag, "_order"}, bad, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_err"}, err_count, e.err);
      check({tag, "_pass"}, pass, e.pass);
      if (e.err != 0) check({tag, "_fv"}, fail_vec, e.fv);
    end
  endtask

  initial begin
    int   d_cnt;
    int   d_first;
    int   d_second;
    int   busy_mid;
    int   w;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    check_idle_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold_busy", busy, 0);
    check("idle_hold_done", done, 0);

    run_one("and", 0);
    repeat (3) @(negedge clk);
    check("done_hold", done, 1);
    check("pass_hold", pass, 1);

    run_one("tied1", 1);
    run_one("tied0", 2);
    run_one("or", 3);

    mode = 0;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(model(0));
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("midrun_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun_rst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy, 0);
    run_one("after_rst", 0);

    mode = 0;
    d_cnt = 0;
    d_first = -1;
    d_second = -1;
    busy_mid = 0;
    @(negedge clk);
    start = 1'b1;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      if (done) begin
        if (d_cnt == 0) d_first = j;
        else if (d_cnt == 1) d_second = j;
        d_cnt++;
      end
      if (j == 30) busy_mid = busy;
    end
    start = 1'b0;
    check("b2b_done_count", d_cnt, 2);
    check("b2b_first", d_first, RUN_LAT);
    check("b2b_second", d_second, 2 * RUN_LAT + 1);
    check("b2b_busy_mid", busy_mid, 1);
    w = 0;
    while (!done && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("b2b_third_done", done, 1);
    check("b2b_third_pass", pass, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
